nihilist_encrypt_stream: RTL and testbench

Byte-serial Nihilist-cipher encryptor that produces the numeric ciphertext consumed by the team's combinational `decrypt` stage. It accepts one plaintext character per valid/ready handshake. It locates the character and the current key letter in the fixed 5x5 Polybius table by a sequential scan, and emits their summed two-digit codes as a stream. A message is exactly MSG_LEN characters and is framed by a `start` pulse and `out_last`.

---
 rtl/nihilist_encrypt_stream_if.sv | 32 +++
 rtl/nihilist_encrypt_stream.sv | 199 +++++++++++++++++++
 tb/tb_nihilist_encrypt_stream.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nihilist_encrypt_stream_if.sv
// ============================================================================
// Module   : nihilist_encrypt_stream_if
// Purpose  : Plaintext-in / ciphertext-out handshake bundle for the
//            byte-serial Nihilist encryptor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface nihilist_encrypt_stream_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_code;
    logic       out_err;
    logic       out_last;
    logic       busy;

    modport master (
        output start, in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_code, out_err, out_last, busy
    );

    modport slave (
        input  start, in_valid, in_char, out_ready,
        output in_ready, out_valid, out_code, out_err, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/nihilist_encrypt_stream.sv
// ============================================================================
// Module   : nihilist_encrypt_stream
// Purpose  : Byte-serial Nihilist encryptor; scans the 5x5 Polybius table for
//            the plaintext char and key letter, emits the summed codes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nihilist_encrypt_stream #(
    parameter int MSG_LEN = 9,
    parameter int SEC_LEN = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    nihilist_encrypt_stream_if.slave    bus
);

    localparam logic [7:0] c_last_n   = 8'(MSG_LEN - 1);
    localparam logic [3:0] c_last_k   = 4'(SEC_LEN - 1);
    localparam logic [4:0] c_scan_end = 5'd25;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_SCAN   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    function automatic logic [7:0] tbl_char(input logic [4:0] idx);
        case (idx)
            5'd0:    tbl_char = "M";
            5'd1:    tbl_char = "A";
            5'd2:    tbl_char = "T";
            5'd3:    tbl_char = "E";
            5'd4:    tbl_char = "I";
            5'd5:    tbl_char = "B";
            5'd6:    tbl_char = "C";
            5'd7:    tbl_char = "D";
            5'd8:    tbl_char = "F";
            5'd9:    tbl_char = "G";
            5'd10:   tbl_char = "H";
            5'd11:   tbl_char = "K";
            5'd12:   tbl_char = "L";
            5'd13:   tbl_char = "N";
            5'd14:   tbl_char = "O";
            5'd15:   tbl_char = "P";
            5'd16:   tbl_char = "Q";
            5'd17:   tbl_char = "R";
            5'd18:   tbl_char = "S";
            5'd19:   tbl_char = "U";
            5'd20:   tbl_char = "V";
            5'd21:   tbl_char = "W";
            5'd22:   tbl_char = "X";
            5'd23:   tbl_char = "Y";
            5'd24:   tbl_char = "Z";
            default: tbl_char = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] key_char(input logic [3:0] idx);
        case (idx)
            4'd0:    key_char = "P";
            4'd1:    key_char = "A";
            4'd2:    key_char = "R";
            4'd3:    key_char = "A";
            4'd4:    key_char = "S";
            4'd5:    key_char = "C";
            4'd6:    key_char = "H";
            4'd7:    key_char = "I";
            4'd8:    key_char = "V";
            default: key_char = 8'h00;
        endcase
    endfunction

    state_t     r_state;
    logic [7:0] r_n;
    logic [3:0] r_k;
    logic [4:0] r_s;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [7:0] r_char;
    logic       r_pfound;
    logic       r_kfound;
    logic [7:0] r_pcode;
    logic [7:0] r_kcode;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [7:0] r_out_code;
    logic       r_out_err;
    logic       r_out_last;
    logic       r_busy;

    logic [7:0] w_tbl;
    logic [7:0] w_key;
    logic [7:0] w_cur_code;

    // Row/column track the scan index so the code needs no divide.
    assign w_tbl      = tbl_char(r_s);
    assign w_key      = key_char(r_k);
    assign w_cur_code = {5'd0, r_row} * 8'd10 + {5'd0, r_col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= 8'd0;
            r_k         <= 4'd0;
            r_s         <= 5'd0;
            r_row       <= 3'd1;
            r_col       <= 3'd1;
            r_char      <= 8'd0;
            r_pfound    <= 1'b0;
            r_kfound    <= 1'b0;
            r_pcode     <= 8'd0;
            r_kcode     <= 8'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_code  <= 8'd0;
            r_out_err   <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_ACCEPT;
                        r_n        <= 8'd0;
                        r_k        <= 4'd0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_char     <= bus.in_char;
                        r_pfound   <= 1'b0;
                        r_kfound   <= 1'b0;
                        r_s        <= 5'd0;
                        r_row      <= 3'd1;
                        r_col      <= 3'd1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Index 25 is the settle cycle after all 25 entries compared.
                    if (r_s == c_scan_end) begin
                        r_out_valid <= 1'b1;
                        r_out_code  <= (r_pfound && r_kfound) ? (r_pcode + r_kcode) : 8'hFF;
                        r_out_err   <= ~r_pfound;
                        r_out_last  <= (r_n == c_last_n);
                        r_state     <= S_OUT;
                    end else begin
                        if (w_tbl == r_char) begin
                            r_pfound <= 1'b1;
                            r_pcode  <= w_cur_code;
                        end
                        if (w_tbl == w_key) begin
                            r_kfound <= 1'b1;
                            r_kcode  <= w_cur_code;
                        end
                        r_s <= r_s + 5'd1;
                        if (r_col == 3'd5) begin
                            r_col <= 3'd1;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_n == c_last_n) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_n        <= r_n + 8'd1;
                            r_k        <= (r_k == c_last_k) ? 4'd0 : r_k + 4'd1;
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCEPT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_err   = r_out_err;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nihilist_encrypt_stream.sv
// ============================================================================
// Module   : tb_nihilist_encrypt_stream
// Purpose  : Scoreboard bench for nihilist_encrypt_stream (9/9 and 12/3 builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nihilist_encrypt_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nihilist_encrypt_stream_if bus1 ();
    nihilist_encrypt_stream_if bus2 ();

    nihilist_encrypt_stream #(.MSG_LEN(9), .SEC_LEN(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    nihilist_encrypt_stream #(.MSG_LEN(12), .SEC_LEN(3)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int code;
        int err;
        int last;
    } beat_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    acc_in_msg = 0;
    bit    abort    = 1'b0;
    bit    prev_valid = 1'b0;
    beat_t sb[$];
    int    lat_q[$];
    beat_t mon_e;
    int    mon_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int code_of(input byte c);
        string t = "MATEIBCDFGHKLNOPQRSUVWXYZ";
        for (int i = 0; i < 25; i++)
            if (t[i] == c) return 10 * (i / 5 + 1) + (i % 5 + 1);
        return 0;
    endfunction

    function automatic int exp_code(input byte c, input int kidx);
        string kk = "PARASCHIV";
        int p;
        p = code_of(c);
        if (p == 0) return 255;
        return p + code_of(kk[kidx]);
    endfunction

    // Output monitor: samples just after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus1.out_valid && !prev_valid) begin
                if (lat_q.size() == 0) check("lat_q_empty", 1, 0);
                else begin
                    mon_t = lat_q.pop_front();
                    check("latency", cyc - mon_t, 26);
                end
            end
            if (bus1.out_valid && bus1.out_ready) begin
                if (sb.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("out_code", int'(bus1.out_code), mon_e.code);
                    check("out_err",  int'(bus1.out_err),  mon_e.err);
                    check("out_last", int'(bus1.out_last), mon_e.last);
                end
            end
            prev_valid = bus1.out_valid;
        end
    end

    task automatic send_msg(input string m);
        bit    got;
        beat_t b;
        acc_in_msg = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < m.len(); i++) begin
            if (abort) begin
                bus1.in_valid = 1'b0;
                return;
            end
            bus1.in_char  = m[i];
            bus1.in_valid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 300 && !got && !abort; w++) begin
                if (bus1.in_ready) got = 1'b1;
                else @(negedge clk);
            end
            if (abort) begin
                bus1.in_valid = 1'b0;
                return;
            end
            if (!got) begin
                check("in_ready_timeout", 0, 1);
                bus1.in_valid = 1'b0;
                return;
            end
            b.code = exp_code(m[i], i % 9);
            b.err  = (b.code == 255) ? 1 : 0;
            b.last = (i == m.len() - 1) ? 1 : 0;
            sb.push_back(b);
            lat_q.push_back(cyc + 1);
            acc_in_msg = i + 1;
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int w = 0; w < 2000 && bus1.busy; w++) @(negedge clk);
        check({tag, "_busy"}, int'(bus1.busy), 0);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    task automatic backpressure();
        int hc, he, hl;
        for (int w = 0; w < 200 && !(bus1.busy && !bus1.in_ready && !bus1.out_valid && acc_in_msg > 0); w++)
            @(negedge clk);
        bus1.out_ready = 1'b0;
        for (int w = 0; w < 200 && !bus1.out_valid; w++) @(negedge clk);
        check("bp_valid", int'(bus1.out_valid), 1);
        hc = int'(bus1.out_code);
        he = int'(bus1.out_err);
        hl = int'(bus1.out_last);
        for (int c = 0; c < 5; c++) begin
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            check("bp_code_hold",  int'(bus1.out_code),  hc);
            check("bp_err_hold",   int'(bus1.out_err),   he);
            check("bp_last_hold",  int'(bus1.out_last),  hl);
            check("bp_in_ready",   int'(bus1.in_ready),  0);
            check("bp_valid_hold", int'(bus1.out_valid), 1);
        end
        bus1.out_ready = 1'b1;
    endtask

    initial begin
        bit got;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.in_char = 8'd0; bus1.out_ready = 1'b1;
        bus2.start = 1'b0; bus2.in_valid = 1'b0; bus2.in_char = 8'd0; bus2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  int'(bus1.in_ready),  0);
        check("rst_out_valid", int'(bus1.out_valid), 0);
        check("rst_out_code",  int'(bus1.out_code),  0);
        check("rst_out_err",   int'(bus1.out_err),   0);
        check("rst_out_last",  int'(bus1.out_last),  0);
        check("rst_busy",      int'(bus1.busy),      0);
        rst = 1'b0;

        send_msg("DYNAMITES"); wait_idle("dynamites");
        send_msg("ZZZZZZZZZ"); wait_idle("zzz");
        send_msg("ABJCDEFGH"); wait_idle("j_msg");

        fork
            send_msg("DYNAMITES");
            backpressure();
        join
        wait_idle("bp_msg");

        // Asynchronous reset while the fourth character is being scanned.
        fork
            send_msg("DYNAMITES");
            begin
                for (int w = 0; w < 2000 && acc_in_msg < 4; w++) @(negedge clk);
                check("rst_mid_reached", (acc_in_msg >= 4) ? 1 : 0, 1);
                repeat (5) @(negedge clk);
                #2 rst = 1'b1;
                abort = 1'b1;
                #1;
                check("mid_rst_in_ready",  int'(bus1.in_ready),  0);
                check("mid_rst_out_valid", int'(bus1.out_valid), 0);
                check("mid_rst_out_code",  int'(bus1.out_code),  0);
                check("mid_rst_out_err",   int'(bus1.out_err),   0);
                check("mid_rst_out_last",  int'(bus1.out_last),  0);
                check("mid_rst_busy",      int'(bus1.busy),      0);
            end
        join
        @(negedge clk);
        sb.delete();
        lat_q.delete();
        abort = 1'b0;
        rst = 1'b0;
        send_msg("DYNAMITES"); wait_idle("after_rst");

        // MSG_LEN=12, SEC_LEN=3 build: key wraps P,A,R.
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus2.in_char  = "A";
            bus2.in_valid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 300 && !got; w++) begin
                if (bus2.in_ready) got = 1'b1;
                else @(negedge clk);
            end
            check("d2_in_ready", int'(got), 1);
            @(negedge clk);
            bus2.in_valid = 1'b0;
            for (int w = 0; w < 300 && !bus2.out_valid; w++) @(negedge clk);
            check("d2_code", int'(bus2.out_code), exp_code("A", i % 3));
            check("d2_last", int'(bus2.out_last), (i == 11) ? 1 : 0);
            @(negedge clk);
        end
        for (int w = 0; w < 50 && bus2.busy; w++) @(negedge clk);
        check("d2_busy", int'(bus2.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
